// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl -- execution sequencer for the single-cycle RV32 core.
// Produces cpu_en, the commit enable that gates PC, register-file and
// data-memory writes. Modes: HALT, single STEP from a debounced pushbutton,
// RUN at one instruction per RUN_DIV clocks, BREAK on a PC match.
// Also counts retired instructions for the 7-segment debug mux.
//
// Ports:
//   clk          system clock
//   rst_n        async active-low reset
//   step_btn_n   raw KEY pushbutton, active-low, asynchronous to clk
//   run_sw       run switch level (1 = run requested)
//   bp_en        breakpoint enable
//   bp_addr      breakpoint PC (byte address)
//   pc           current PC from the core
//   cnt_clr      synchronous clear of instr_count
//   cpu_en       commit enable, one pulse per retired instruction
//   state        00 HALT, 01 STEP, 10 RUN, 11 BREAK
//   bp_hit       high while in BREAK
//   instr_count  retired-instruction count (wraps)
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RUN_DIV         = 25000000,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_btn_n,
  input  logic             run_sw,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  input  logic             cnt_clr,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_STEP = 2'b01,
    S_RUN  = 2'b10,
    S_BRK  = 2'b11
  } state_e;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(RUN_DIV - 1);

  // Button path: 2-FF synchronizer + level debouncer
  logic          sync1_q, sync2_q, db_q, step_pulse_q;
  logic [DW-1:0] dcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      db_q         <= 1'b1;
      dcnt_q       <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      sync1_q      <= step_btn_n;
      sync2_q      <= sync1_q;
      step_pulse_q <= 1'b0;
      if (sync2_q == db_q) begin
        dcnt_q <= '0;
      end else if (dcnt_q == DB_LAST) begin
        // Last required differing sample: accept the new level. Only the
        // press edge (1->0) fires a step.
        dcnt_q       <= '0;
        db_q         <= sync2_q;
        step_pulse_q <= ~sync2_q;
      end else begin
        dcnt_q <= dcnt_q + DW'(1);
      end
    end
  end

  // FSM next state, prescaler next state
  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic          bp_match;

  assign bp_match = bp_en & (pc == bp_addr);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HALT: if (step_pulse_q) state_d = S_STEP;
              else if (run_sw)  state_d = S_RUN;
      S_STEP: state_d = S_HALT;
      S_RUN:  if (bp_match)     state_d = S_BRK;
              else if (!run_sw) state_d = S_HALT;
      S_BRK:  if (step_pulse_q) state_d = S_STEP;
              else if (!run_sw) state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // Prescaler counts only while staying in RUN, so every RUN entry starts
  // at 0. tick is computed from the next count so it is registered yet
  // coincides with the cycle in which the count sits at RUN_DIV-1 (wrap).
  always_comb begin
    pre_d = '0;
    if (state_d == S_RUN && state_q == S_RUN)
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    tick_d = (state_d == S_RUN) && (pre_d == PRE_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HALT;
      pre_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
    end
  end

  // A matching PC is never committed in RUN; STEP commits unconditionally
  // so the core can step off a breakpoint.
  assign cpu_en = (state_q == S_STEP) | ((state_q == S_RUN) & tick_q & ~bp_match);
  assign state  = state_q;
  assign bp_hit = (state_q == S_BRK);

  // Retired-instruction counter; clear wins over a coincident commit
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (cnt_clr) cnt_q <= '0;
    else if (cpu_en)  cnt_q <= cnt_q + CNT_W'(1);
  end

  assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl. Main instance: DEBOUNCE_CYCLES=4,
// RUN_DIV=3. A second small instance (DEBOUNCE_CYCLES=1, RUN_DIV=1,
// CNT_W=4) covers the every-cycle run rate and counter wrap.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        step_btn_n = 1'b1;
  logic        run_sw = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [31:0] pc;
  logic        cnt_clr = 1'b0;
  logic        cpu_en;
  logic [1:0]  state;
  logic        bp_hit;
  logic [31:0] instr_count;

  logic        run_sw2 = 1'b0;
  logic        cpu_en2;
  logic [1:0]  state2;
  logic        bp_hit2;
  logic [3:0]  cnt2;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(3), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .step_btn_n(step_btn_n), .run_sw(run_sw),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .cnt_clr(cnt_clr),
    .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit), .instr_count(instr_count)
  );

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(1), .RUN_DIV(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .step_btn_n(1'b1), .run_sw(run_sw2),
    .bp_en(1'b0), .bp_addr(32'h0), .pc(32'h0), .cnt_clr(1'b0),
    .cpu_en(cpu_en2), .state(state2), .bp_hit(bp_hit2), .instr_count(cnt2)
  );

  // Core model: PC advances by 4 per commit; commit/step activity logged
  logic        pc_load = 1'b1;
  logic [31:0] pc_m = 32'h0;
  logic [31:0] last_pc = 32'h0;
  int          commits = 0;
  int          steps = 0;

  assign pc = pc_m;

  always @(posedge clk) begin
    if (pc_load)     pc_m <= 32'h0;
    else if (cpu_en) pc_m <= pc_m + 32'd4;
    if (cpu_en === 1'b1) begin
      commits <= commits + 1;
      last_pc <= pc;
    end
    if (state === 2'b01) steps <= steps + 1;
  end

  int n_chk = 0;
  int n_err = 0;
  int c0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // 1. async reset mid-cycle, then idle
    #3 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_en", 32'(cpu_en), 32'd0);
    chk("rst_cnt", instr_count, 32'd0);
    chk("rst_bphit", 32'(bp_hit), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pc_load = 1'b0;
    repeat (20) tick();
    chk("idle_commits", 32'(commits), 32'd0);
    chk("idle_state", 32'(state), 32'd0);

    // 2. debounced step, then a short glitch
    step_btn_n = 1'b0;
    repeat (7) tick();
    chk("step_state", 32'(state), 32'd1);
    chk("step_en", 32'(cpu_en), 32'd1);
    tick();
    chk("step_back", 32'(state), 32'd0);
    chk("step_cnt", instr_count, 32'd1);
    repeat (2) tick();
    step_btn_n = 1'b1;
    repeat (10) tick();
    chk("step_once", 32'(steps), 32'd1);
    chk("step_commits", 32'(commits), 32'd1);
    step_btn_n = 1'b0;
    repeat (3) tick();
    step_btn_n = 1'b1;
    repeat (10) tick();
    chk("glitch_steps", 32'(steps), 32'd1);
    chk("glitch_cnt", instr_count, 32'd1);

    // 3. run rate 1/3
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr", instr_count, 32'd0);
    c0 = commits;
    run_sw = 1'b1;
    tick();
    chk("run_enter", 32'(state), 32'd2);
    repeat (30) tick();
    chk("run_pulses", 32'(commits - c0), 32'd10);
    chk("run_cnt", instr_count, 32'd10);
    run_sw = 1'b0;
    tick();
    chk("run_stop", 32'(state), 32'd0);
    c0 = commits;
    repeat (6) tick();
    chk("halt_quiet", 32'(commits - c0), 32'd0);

    // 4. breakpoint at 0xC
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    chk("pc_zero", pc, 32'h0);
    bp_en = 1'b1;
    bp_addr = 32'h0000_000C;
    c0 = commits;
    run_sw = 1'b1;
    repeat (11) tick();
    chk("bp_state", 32'(state), 32'd3);
    chk("bp_hit", 32'(bp_hit), 32'd1);
    chk("bp_pc", pc, 32'hC);
    chk("bp_commits", 32'(commits - c0), 32'd3);
    chk("bp_lastpc", last_pc, 32'h8);
    chk("bp_noen", 32'(cpu_en), 32'd0);
    repeat (3) tick();
    chk("bp_hold", 32'(state), 32'd3);
    chk("bp_hold_commits", 32'(commits - c0), 32'd3);
    step_btn_n = 1'b0;
    repeat (7) tick();
    chk("bpstep_state", 32'(state), 32'd1);
    chk("bpstep_en", 32'(cpu_en), 32'd1);
    chk("bpstep_pc", pc, 32'hC);
    tick();
    chk("bpstep_halt", 32'(state), 32'd0);
    chk("bpstep_pc2", pc, 32'h10);
    tick();
    chk("resume_run", 32'(state), 32'd2);
    repeat (2) tick();
    chk("resume_en", 32'(cpu_en), 32'd1);
    chk("resume_pc", pc, 32'h10);
    tick();
    chk("resume_pc2", pc, 32'h14);
    step_btn_n = 1'b1;
    run_sw = 1'b0;
    tick();
    chk("resume_stop", 32'(state), 32'd0);
    repeat (8) tick();

    // 5. enter RUN on bp, step-vs-halt priority, clear vs commit
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    bp_addr = 32'h0;
    c0 = commits;
    run_sw = 1'b1;
    tick();
    chk("bp0_run", 32'(state), 32'd2);
    chk("bp0_noen", 32'(cpu_en), 32'd0);
    tick();
    chk("bp0_brk", 32'(state), 32'd3);
    chk("bp0_commits", 32'(commits - c0), 32'd0);
    step_btn_n = 1'b0;
    repeat (6) tick();
    run_sw = 1'b0;
    chk("prio_pre", 32'(state), 32'd3);
    tick();
    chk("prio_step", 32'(state), 32'd1);
    chk("prio_en", 32'(cpu_en), 32'd1);
    tick();
    chk("prio_halt", 32'(state), 32'd0);
    chk("prio_pc", pc, 32'h4);
    step_btn_n = 1'b1;
    repeat (8) tick();
    step_btn_n = 1'b0;
    repeat (7) tick();
    chk("clr_step_en", 32'(cpu_en), 32'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_vs_en", instr_count, 32'd0);
    chk("clr_pc", pc, 32'h8);
    step_btn_n = 1'b1;
    repeat (8) tick();

    // RUN_DIV=1 rate and 4-bit wrap on the second instance
    run_sw2 = 1'b1;
    tick();
    chk("div1_state", 32'(state2), 32'd2);
    chk("div1_en", 32'(cpu_en2), 32'd1);
    repeat (15) tick();
    chk("wrap_max", 32'(cnt2), 32'd15);
    tick();
    chk("wrap_zero", 32'(cnt2), 32'd0);
    run_sw2 = 1'b0;

    // async reset in the middle of RUN
    run_sw = 1'b1;
    repeat (5) tick();
    chk("mid_cnt", instr_count, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_cnt", instr_count, 32'd0);
    chk("mid_rst_en", 32'(cpu_en), 32'd0);
    chk("mid_rst_cnt2", 32'(cnt2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Execution sequencer for the single-cycle RV32 core on the DE-series board. It produces the commit enable `cpu_en` that gates the PC, register-file and data-memory writes. It supports four modes:
- halt
- single-step from a debounced pushbutton
- free run at a divided rate
- stop at a PC breakpoint

It also counts retired instructions for the 7-segment debug mux.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples needed to accept a new button level (≥1)
RUN_DIV, 25000000, clk cycles per executed instruction in RUN mode (≥1; 1 = every cycle)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  reset, asynchronous, active-low
step_btn_n  in  1  raw KEY pushbutton, active-low, asynchronous to clk
run_sw  in  1  run switch level (1 = run requested)
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC (byte address)
pc  in  32  current PC from core pc register
cnt_clr  in  1  synchronous clear of instr_count
cpu_en  out  1  commit enable to PC/regfile/dmem; one pulse = one retired instruction
state  out  2  FSM state: 00 HALT, 01 STEP, 10 RUN, 11 BREAK
bp_hit  out  1  high while state == BREAK
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n=0, async, takes effect immediately, including mid-run):
  - state=HALT, cpu_en=0, bp_hit=0, instr_count=0.
  - Synchronizer FFs=1, debounced level=1, debounce counter=0, prescaler=0, tick=0.
- Button path:
  - 2-FF synchronizer, then debouncer.
  - Counter increments while the synced level differs from the debounced level, and clears when they are equal.
  - On reaching DEBOUNCE_CYCLES, the debounced level takes the synced level and the counter clears.
  - `step_pulse` is registered and high for exactly 1 cycle after the debounced level goes 1→0. Release produces no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Prescaler:
  - Runs only in RUN and is held at 0 in all other states.
  - Counts 0..RUN_DIV-1. The registered `tick` is high in the cycle the count wraps.
  - With RUN_DIV=1, `tick` is high every RUN cycle.
- bp_match = bp_en & (pc == bp_addr), full 32-bit compare.
- FSM (registered state; priorities listed highest first):
  - HALT: step_pulse → STEP; else run_sw → RUN; else stay.
  - STEP: always → HALT next cycle. The breakpoint is ignored, so stepping off a breakpoint is allowed.
  - RUN:
    - bp_match → BREAK.
    - Else !run_sw → HALT.
    - Else stay.
    - step_pulse is ignored in RUN.
  - BREAK: step_pulse → STEP; else !run_sw → HALT; else stay.
- cpu_en is combinational from registered signals only:
  - (state==STEP) | (state==RUN & tick & !bp_match).
  - Never high in HALT or BREAK.
  - A breakpoint instruction is never committed in RUN.
- Resuming from a breakpoint:
  - Press step: executes the breakpoint instruction, then HALT.
  - If run_sw is still 1, the next cycle enters RUN.
  - Entering RUN with pc==bp_addr (bp_en=1) goes to BREAK the following cycle with no commit.
- instr_count:
  - Increments on every cycle with cpu_en=1 and wraps at 2^CNT_W-1 → 0.
  - cnt_clr has priority: count=0 that cycle, and a simultaneous cpu_en is not counted.
- bp_hit = (state==BREAK), decoded from the registered state; no extra latency.

Test Plan:
1. Reset/idle. Bench parameters: DEBOUNCE_CYCLES=4, RUN_DIV=3. Drive rst_n low mid-cycle → state=00, cpu_en=0, instr_count=0 asynchronously. Release with run_sw=0 for 20 cycles → cpu_en stays 0.
2. Debounced step.
   - Hold step_btn_n low for 10 cycles → exactly one step_pulse; state 00→01→00; exactly one cpu_en cycle; instr_count=1.
   - A 3-cycle low glitch → no pulse, count unchanged.
3. Run rate. run_sw=1, bp_en=0 for 30 cycles after entering RUN → cpu_en high every 3rd cycle (10 pulses, instr_count=10). Then run_sw=0 → HALT next cycle, no further cpu_en.
4. Breakpoint.
   - Setup: bp_en=1, bp_addr=0x0000000C, model pc advancing +4 per cpu_en from 0. run_sw=1 → commits at pc=0,4,8. With pc=0xC: state=11, bp_hit=1, no cpu_en.
   - Press step → one cpu_en at pc=0xC (STEP), HALT, then RUN and pc=0x10 commits.
5. Priority and clear.
   - In BREAK, a simultaneous step_pulse with run_sw=0 → STEP, not HALT.
   - cnt_clr coincident with cpu_en → instr_count=0.
   - Preload count 0xFFFFFFFF (force) plus one cpu_en → wraps to 0.
